cu_sequencer: RTL and testbench
===============================

Name: cu_sequencer

Overview:
- Parametrised successor to the per-instruction MOV/ALU control FSMs: one multi-cycle sequencer that fetches an instruction word, decodes it and drives register-file read/write strobes and selects, ALU function/latch enables and the program counter.
- Adds to the earlier control unit:
  - a fetch handshake;
  - an owned PC register;
  - LDI, NOP and HALT instructions;
  - optional jumps;
  - illegal-opcode reporting.
- It replaces the tristate-shared per-opcode FSMs.

Parameters:
- RSEL_W, 5, register-select width; register file depth is 2**RSEL_W.
- PC_W, 5, program-counter width; must satisfy PC_W <= 2*RSEL_W.
- IW, 4+3*RSEL_W, instruction width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc_load  in  1  synchronous PC load / abort
- pc_init  in  PC_W  value loaded on pc_load
- instr  in  IW  fields: opc[IW-1:IW-4], dst[3R-1:2R], src2[2R-1:R], src1[R-1:0], where R=RSEL_W
- instr_valid  in  1  instr present
- instr_ready  out  1  sequencer accepting an instruction
- zero_flag  in  1  ALU zero flag
- pc  out  PC_W  current PC
- rd, wr  out  1  register-file read/write strobes
- rd_sel, wr_sel  out  RSEL_W  register selects
- alu_fs  out  2  ALU function
- c_en  out  1  ALU result latch enable
- f_en  out  1  flag latch enable
- imm_en  out  1  write-data mux selects imm instead of the read bus
- imm  out  2*RSEL_W  immediate, {src2,src1}
- halted  out  1  high in HALT
- illegal  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, pc=0, latched instruction=0.
  - All strobes, selects, alu_fs, imm, halted and illegal are 0; instr_ready=1.
- Outputs are registered or decoded only from state plus the latched instruction, never from instr directly.
- FETCH:
  - instr_ready=1.
  - If instr_valid, latch instr and go to DEC; otherwise stay.
- DEC: all strobes 0. Dispatch on opc:
  - 00ff ALU -> A_LDA
  - 0100 MOV -> MOV
  - 0101 LDI -> LDI
  - 0110 JMP -> JMP
  - 0111 JZ -> JMP
  - 1000 NOP -> FETCH, pc+1
  - 1001 HALT -> HALT
  - anything else: illegal=1 for this cycle, -> FETCH, pc+1
- ALU sequence, one cycle each:
  - A_LDA: rd=1, rd_sel=src1, wr=1, wr_sel=0.
  - A_LDB: rd=1, rd_sel=src2, wr=1, wr_sel=1.
  - A_EXE: c_en=1, alu_fs=opc[1:0], wr=1, wr_sel=dst.
  - A_FLG: f_en=1, wr=1, wr_sel=all-ones (flag register).
  - Then -> FETCH, pc+1.
- MOV: rd=1, rd_sel=src1, wr=1, wr_sel=dst; -> FETCH, pc+1.
- LDI: imm_en=1, imm={src2,src1}, wr=1, wr_sel=dst; -> FETCH, pc+1.
- JMP state (JMP or JZ):
  - JMP: pc <= instr[PC_W-1:0].
  - JZ: pc <= target if zero_flag is sampled 1 in this state, else pc+1.
  - Then -> FETCH.
- HALT: halted=1 and instr_ready=0. Exited only by reset or pc_load.
- PC arithmetic: increment is modulo 2**PC_W, so the maximum value wraps to 0.
- Instruction latency:
  - ALU: 6 cycles (FETCH accept through A_FLG).
  - MOV, LDI, JMP: 3 cycles.
  - NOP and illegal: 2 cycles.
  - Back-to-back instructions accepted with no bubbles beyond these.
- pc_load:
  - Acts in any state and has priority over every other transition.
  - pc <= pc_init, state <= FETCH, strobes 0 next cycle.
  - An aborted instruction has no further writes. halted clears.
- rst_n asserted mid-instruction: immediate return to reset values; no partial write is completed.
- While not in FETCH, instr and instr_valid are ignored.

Optional Feature:
- Macro: CU_SEQ_BRANCH_EN.
- Defined: JMP and JZ behave as above.
- Undefined: opcodes 0110 and 0111 are illegal (illegal pulse, pc+1), the JMP state and the zero_flag logic are absent, and zero_flag is unused.

Test Plan:
- Reset, then MOV instr opc=0100, dst=3, src1=7 with valid held -> instr_ready=1 at reset; MOV state gives rd_sel=7, wr_sel=3, rd=wr=1; pc 0->1; 3 cycles total.
- ALU opc=0010, dst=4, src2=2, src1=5 -> wr_sel sequence 0,1,4,31 with rd_sel 5,2; alu_fs=2'b10 with c_en in A_EXE; f_en in A_FLG; pc+1.
- LDI dst=9, src2=0x03, src1=0x11 -> imm_en=1, imm=0x071, wr_sel=9; then NOP followed by opc=1111 -> pc advances by 2 total and illegal pulses exactly once.
- PC wrap: pc_load with pc_init=31, then MOV -> pc=0. HALT at pc=5 -> halted=1, instr_ready=0 for 20 cycles, pc stays 5; pc_load pc_init=2 -> halted=0, pc=2.
- CU_SEQ_BRANCH_EN defined:
  - JMP target 17 -> pc=17.
  - JZ target 9 with zero_flag=0 -> pc=18.
  - JZ target 9 with zero_flag=1 -> pc=9.
  - Undefined build: opc=0110 -> illegal pulse, pc+1.
- Assert rst_n=0 during A_EXE -> wr, c_en and all selects go 0 asynchronously; pc=0; after release, state is FETCH with instr_ready=1.

Source files
------------

// File: rtl/cu_sequencer.sv
// Multi-cycle control sequencer. It fetches an instruction word, decodes it, and drives the register-file,
// ALU and PC controls. Define CU_SEQ_BRANCH_EN to enable JMP/JZ; without it those opcodes report as illegal.
module cu_sequencer #(
    parameter  int RSEL_W = 5,
    parameter  int PC_W   = 5,
    localparam int IW     = 4 + 3*RSEL_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_load,
    input  logic [PC_W-1:0]     pc_init,
    input  logic [IW-1:0]       instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic                zero_flag,
    output logic [PC_W-1:0]     pc,
    output logic                rd,
    output logic                wr,
    output logic [RSEL_W-1:0]   rd_sel,
    output logic [RSEL_W-1:0]   wr_sel,
    output logic [1:0]          alu_fs,
    output logic                c_en,
    output logic                f_en,
    output logic                imm_en,
    output logic [2*RSEL_W-1:0] imm,
    output logic                halted,
    output logic                illegal
);

    localparam logic [3:0] OP_MOV  = 4'b0100;
    localparam logic [3:0] OP_LDI  = 4'b0101;
    localparam logic [3:0] OP_NOP  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1001;
`ifdef CU_SEQ_BRANCH_EN
    localparam logic [3:0] OP_JMP  = 4'b0110;
    localparam logic [3:0] OP_JZ   = 4'b0111;
`endif

    typedef enum logic [3:0] {
        S_FETCH,
        S_DEC,
        S_A_LDA,
        S_A_LDB,
        S_A_EXE,
        S_A_FLG,
        S_MOV,
        S_LDI,
`ifdef CU_SEQ_BRANCH_EN
        S_JMP,
`endif
        S_HALT
    } state_t;

    state_t            state, state_nx;
    logic [PC_W-1:0]   pc_nx;
    logic [IW-1:0]     ir;
    logic              ir_load;
    logic              opc_known;
    logic [3:0]        opc;
    logic [RSEL_W-1:0] dst, src2, src1;

    assign opc  = ir[IW-1 -: 4];
    assign dst  = ir[3*RSEL_W-1 -: RSEL_W];
    assign src2 = ir[2*RSEL_W-1 -: RSEL_W];
    assign src1 = ir[RSEL_W-1:0];

`ifdef CU_SEQ_BRANCH_EN
    assign opc_known = (opc[3:2] == 2'b00) || (opc == OP_MOV) || (opc == OP_LDI) ||
                       (opc == OP_JMP) || (opc == OP_JZ) || (opc == OP_NOP) || (opc == OP_HALT);
`else
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag;
    assign opc_known = (opc[3:2] == 2'b00) || (opc == OP_MOV) || (opc == OP_LDI) ||
                       (opc == OP_NOP) || (opc == OP_HALT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (ir_load)
                ir <= instr;
        end
    end

    // pc_load is applied last, so it overrides every transition, including a fetch accept.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        case (state)
            S_FETCH: if (instr_valid) state_nx = S_DEC;
            S_DEC: begin
                if (opc[3:2] == 2'b00) begin
                    state_nx = S_A_LDA;
                end else begin
                    case (opc)
                        OP_MOV:  state_nx = S_MOV;
                        OP_LDI:  state_nx = S_LDI;
                        OP_HALT: state_nx = S_HALT;
`ifdef CU_SEQ_BRANCH_EN
                        OP_JMP, OP_JZ: state_nx = S_JMP;
`endif
                        default: begin
                            state_nx = S_FETCH;
                            pc_nx    = pc + PC_W'(1);
                        end
                    endcase
                end
            end
            S_A_LDA: state_nx = S_A_LDB;
            S_A_LDB: state_nx = S_A_EXE;
            S_A_EXE: state_nx = S_A_FLG;
            S_A_FLG, S_MOV, S_LDI: begin
                state_nx = S_FETCH;
                pc_nx    = pc + PC_W'(1);
            end
`ifdef CU_SEQ_BRANCH_EN
            S_JMP: begin
                state_nx = S_FETCH;
                if (opc == OP_JMP || zero_flag)
                    pc_nx = ir[PC_W-1:0];
                else
                    pc_nx = pc + PC_W'(1);
            end
`endif
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_FETCH;
        endcase
        if (pc_load) begin
            state_nx = S_FETCH;
            pc_nx    = pc_init;
        end
    end

    assign ir_load = (state == S_FETCH) && instr_valid && !pc_load;

    always_comb begin
        instr_ready = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        rd_sel      = '0;
        wr_sel      = '0;
        alu_fs      = 2'b00;
        c_en        = 1'b0;
        f_en        = 1'b0;
        imm_en      = 1'b0;
        imm         = '0;
        halted      = 1'b0;
        illegal     = 1'b0;
        case (state)
            S_FETCH: instr_ready = 1'b1;
            S_DEC:   illegal     = !opc_known;
            S_A_LDA: begin
                rd     = 1'b1;
                rd_sel = src1;
                wr     = 1'b1;
            end
            S_A_LDB: begin
                rd     = 1'b1;
                rd_sel = src2;
                wr     = 1'b1;
                wr_sel = RSEL_W'(1);
            end
            S_A_EXE: begin
                c_en   = 1'b1;
                alu_fs = opc[1:0];
                wr     = 1'b1;
                wr_sel = dst;
            end
            // The all-ones register holds the ALU flags.
            S_A_FLG: begin
                f_en   = 1'b1;
                wr     = 1'b1;
                wr_sel = '1;
            end
            S_MOV: begin
                rd     = 1'b1;
                rd_sel = src1;
                wr     = 1'b1;
                wr_sel = dst;
            end
            S_LDI: begin
                imm_en = 1'b1;
                imm    = {src2, src1};
                wr     = 1'b1;
                wr_sel = dst;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// Scoreboard bench for cu_sequencer. Expected register-file and illegal events are queued by the stimulus
// and checked by a monitor; PC, latency and handshake values are checked directly.
module tb_cu_sequencer;

    localparam int RSEL_W = 5;
    localparam int PC_W   = 5;
    localparam int IW     = 4 + 3*RSEL_W;

    typedef struct packed {
        logic        rd;
        logic [4:0]  rd_sel;
        logic [4:0]  wr_sel;
        logic [1:0]  alu_fs;
        logic        c_en;
        logic        f_en;
        logic        imm_en;
        logic [9:0]  imm;
        logic        illegal;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pc_load = 1'b0;
    logic [PC_W-1:0]   pc_init = '0;
    logic [IW-1:0]     instr = '0;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic              zero_flag = 1'b0;
    logic [PC_W-1:0]   pc;
    logic              rd, wr;
    logic [RSEL_W-1:0] rd_sel, wr_sel;
    logic [1:0]        alu_fs;
    logic              c_en, f_en, imm_en;
    logic [2*RSEL_W-1:0] imm;
    logic              halted, illegal;

    int   total = 0;
    int   bad = 0;
    ev_t  exp_q[$];
    ev_t  mon_act, mon_exp;

    cu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .pc_init(pc_init),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .zero_flag(zero_flag), .pc(pc), .rd(rd), .wr(wr), .rd_sel(rd_sel),
        .wr_sel(wr_sel), .alu_fs(alu_fs), .c_en(c_en), .f_en(f_en),
        .imm_en(imm_en), .imm(imm), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mk_instr(input logic [3:0] opc, input logic [4:0] dst,
                                               input logic [4:0] src2, input logic [4:0] src1);
        return {opc, dst, src2, src1};
    endfunction

    function automatic ev_t mk_ev(input logic r, input logic [4:0] rs, input logic [4:0] ws,
                                  input logic [1:0] fs, input logic c, input logic f,
                                  input logic ie, input logic [9:0] im, input logic ill);
        ev_t e;
        e.rd = r; e.rd_sel = rs; e.wr_sel = ws; e.alu_fs = fs; e.c_en = c;
        e.f_en = f; e.imm_en = ie; e.imm = im; e.illegal = ill;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every cycle that writes the register file or flags an illegal opcode must match the next queued event.
    always @(negedge clk) begin
        if (wr || illegal) begin
            mon_act = {rd, rd_sel, wr_sel, alu_fs, c_en, f_en, imm_en, imm, illegal};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_event: got %h expected none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    bad++;
                    $display("[TB] FAIL event: got %h expected %h", mon_act, mon_exp);
                end
            end
        end
    end

    // Entered at a falling edge; lat==0 returns right after the accepting edge.
    task automatic applyStimulus(input logic [IW-1:0] word, input int lat, input int exp_pc);
        int n = 0;
        instr       = word;
        instr_valid = 1'b1;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_ready", 32'(instr_ready), 1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        if (lat > 0) begin
            n = 0;
            @(negedge clk);
            while (!instr_ready && n < 50) begin
                n++;
                @(negedge clk);
            end
            checkOutput("latency", n, lat - 1);
            checkOutput("pc", 32'(pc), exp_pc);
        end
    endtask

    task automatic loadPc(input logic [PC_W-1:0] v);
        pc_load     = 1'b1;
        pc_init     = v;
        instr_valid = 1'b0;
        @(posedge clk);
        #1 pc_load = 1'b0;
        checkOutput("pc_load_pc", 32'(pc), 32'(v));
        checkOutput("pc_load_ready", 32'(instr_ready), 1);
        checkOutput("pc_load_halted", 32'(halted), 0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #3;
        checkOutput("rst_ready", 32'(instr_ready), 1);
        checkOutput("rst_pc", 32'(pc), 0);
        checkOutput("rst_strobes", {28'd0, rd, wr, c_en, f_en}, 0);
        checkOutput("rst_sels", {22'd0, rd_sel, wr_sel}, 0);
        checkOutput("rst_imm", {20'd0, imm_en, halted, imm}, 0);
        checkOutput("rst_illegal", 32'(illegal), 0);
        @(negedge clk);
        rst_n = 1'b1;

        exp_q.push_back(mk_ev(1'b1, 5'd7, 5'd3, 2'd0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0));
        applyStimulus(mk_instr(4'b0100, 5'd3, 5'd0, 5'd7), 3, 1);

        exp_q.push_back(mk_ev(1'b1, 5'd5, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0));
        exp_q.push_back(mk_ev(1'b1, 5'd2, 5'd1, 2'd0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0));
        exp_q.push_back(mk_ev(1'b0, 5'd0, 5'd4, 2'b10, 1'b1, 1'b0, 1'b0, 10'h0, 1'b0));
        exp_q.push_back(mk_ev(1'b0, 5'd0, 5'd31, 2'd0, 1'b0, 1'b1, 1'b0, 10'h0, 1'b0));
        applyStimulus(mk_instr(4'b0010, 5'd4, 5'd2, 5'd5), 6, 2);

        exp_q.push_back(mk_ev(1'b0, 5'd0, 5'd9, 2'd0, 1'b0, 1'b0, 1'b1, 10'h071, 1'b0));
        applyStimulus(mk_instr(4'b0101, 5'd9, 5'h03, 5'h11), 3, 3);

        applyStimulus(mk_instr(4'b1000, 5'd0, 5'd0, 5'd0), 2, 4);
        exp_q.push_back(mk_ev(1'b0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b1));
        applyStimulus(mk_instr(4'b1111, 5'd0, 5'd0, 5'd0), 2, 5);

        // HALT at pc 5 while a MOV is held on the input; it must be ignored.
        applyStimulus(mk_instr(4'b1001, 5'd0, 5'd0, 5'd0), 0, 0);
        instr       = mk_instr(4'b0100, 5'd2, 5'd0, 5'd1);
        instr_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("halt_halted", 32'(halted), 1);
            checkOutput("halt_ready", 32'(instr_ready), 0);
            checkOutput("halt_pc", 32'(pc), 5);
        end
        loadPc(5'd2);

`ifdef CU_SEQ_BRANCH_EN
        applyStimulus(mk_instr(4'b0110, 5'd0, 5'd0, 5'd17), 3, 17);
        zero_flag = 1'b0;
        applyStimulus(mk_instr(4'b0111, 5'd0, 5'd0, 5'd9), 3, 18);
        zero_flag = 1'b1;
        applyStimulus(mk_instr(4'b0111, 5'd0, 5'd0, 5'd9), 3, 9);
        zero_flag = 1'b0;
`else
        exp_q.push_back(mk_ev(1'b0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b1));
        applyStimulus(mk_instr(4'b0110, 5'd0, 5'd0, 5'd17), 2, 3);
        exp_q.push_back(mk_ev(1'b0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b1));
        applyStimulus(mk_instr(4'b0111, 5'd0, 5'd0, 5'd9), 2, 4);
`endif

        loadPc(5'd31);
        exp_q.push_back(mk_ev(1'b1, 5'd2, 5'd1, 2'd0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0));
        applyStimulus(mk_instr(4'b0100, 5'd1, 5'd0, 5'd2), 3, 0);

        // Reset arrives in A_EXE: only the two load cycles may be written.
        exp_q.push_back(mk_ev(1'b1, 5'd4, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0));
        exp_q.push_back(mk_ev(1'b1, 5'd3, 5'd1, 2'd0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0));
        applyStimulus(mk_instr(4'b0001, 5'd6, 5'd3, 5'd4), 0, 0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("exe_c_en", 32'(c_en), 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("arst_wr_cen", {30'd0, wr, c_en}, 0);
        checkOutput("arst_sels", {22'd0, rd_sel, wr_sel}, 0);
        checkOutput("arst_alu_fs", 32'(alu_fs), 0);
        checkOutput("arst_pc", 32'(pc), 0);
        checkOutput("arst_ready", 32'(instr_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_ready", 32'(instr_ready), 1);
        checkOutput("post_rst_wr", 32'(wr), 0);

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
